// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of a synchronous FIFO between N_REQ producers.
// Producers are served round-robin. Each grant lasts until the producer has
// written MAX_BURST words or drops its request. FIFO full back-pressure
// freezes the grant, so no word is ever offered to a full FIFO.
//
// Ports
//   clk           in   system clock, all state changes on posedge
//   rst_n         in   asynchronous active-low reset
//   req           in   [N_REQ]             per-producer write request
//   req_data      in   [N_REQ*DATA_WIDTH]  producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt           out  [N_REQ]             registered one-hot grant, 0 when idle
//   gnt_id        out  [$clog2(N_REQ)]     index of granted producer, 0 when idle
//   accept        out  [N_REQ]             word consumed from producer i this cycle
//   fifo_w_en     out  FIFO write enable (OR of accept)
//   fifo_data_in  out  [DATA_WIDTH]        granted producer's word, 0 when idle
//   fifo_full     in   FIFO full flag
//   busy          out  registered, high while a grant is active
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              gnt,
  output logic [$clog2(N_REQ)-1:0]      gnt_id,
  output logic [N_REQ-1:0]              accept,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  output logic                          busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  burst_cnt;

  logic              cur_req;
  logic              last_beat;
  logic              rel_grant;
  logic [ID_W-1:0]   next_ptr;
  logic [ID_W-1:0]   search_base;
  logic              found;
  logic [ID_W-1:0]   pick_id;
  logic [N_REQ-1:0]  pick_onehot;

  // Write-side handshake. gnt is registered and one-hot, so gating it with
  // req and ~fifo_full gives the per-producer accept directly; the FIFO can
  // never see a write while it reports full.
  always_comb begin
    accept    = gnt & req & {N_REQ{~fifo_full}};
    fifo_w_en = |accept;
  end

  // Data mux driven by the one-hot grant, which makes the idle value zero
  // without a separate qualifier.
  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Release decision for the current grant. A full FIFO blocks both release
  // paths: the counter cannot advance and a dropped request is not honoured
  // until the FIFO has room again.
  always_comb begin
    cur_req   = |(gnt & req);
    last_beat = fifo_w_en && (burst_cnt == CNT_W'(MAX_BURST - 1));
    rel_grant = (state == GRANT) && (last_beat || (!cur_req && !fifo_full));
    next_ptr  = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  // Round-robin search. When releasing, the search starts just after the
  // current owner, so the owner itself is examined last and only wins when
  // nobody else is waiting.
  always_comb begin
    search_base = (state == GRANT) ? next_ptr : rr_ptr;
    found       = 1'b0;
    pick_id     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(search_base) + k) % N_REQ]) begin
        found   = 1'b1;
        pick_id = ID_W'((int'(search_base) + k) % N_REQ);
      end
    end
    pick_onehot = N_REQ'(1) << pick_id;
  end

  // Grant FSM with registered outputs. A release that finds another pending
  // request loads the new grant in the same edge, so there is no idle
  // bubble between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gnt       <= pick_onehot;
            gnt_id    <= pick_id;
            busy      <= 1'b1;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (rel_grant) begin
            rr_ptr    <= next_ptr;
            burst_cnt <= '0;
            if (found) begin
              gnt    <= pick_onehot;
              gnt_id <= pick_id;
            end else begin
              state  <= IDLE;
              gnt    <= '0;
              gnt_id <= '0;
              busy   <= 1'b0;
            end
          end else if (fifo_w_en) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the grant logic.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> !fifo_w_en);
  a_burst_bound: assert property (@(posedge clk) disable iff (!rst_n) burst_cnt <= CNT_W'(MAX_BURST));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Drives fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=8, MAX_BURST=4) from producer
// models with a fixed word budget each, plus an 8-deep FIFO model that can
// be drained every cycle or left to fill. A behavioural arbiter model
// (owner index, words-in-burst count, round-robin start) predicts every
// output, checked each negedge; directed literal checks pin key moments.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int FIFO_DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [3:0]  accept;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic        fifo_full;
  logic        busy;

  logic        force_full;
  logic        fifo_at_full;
  logic        drain;

  int          checks;
  int          errors;

  int          rem [4];
  logic [7:0]  pdata [4];
  logic [7:0]  base [4];

  logic [7:0]  fq [$];
  int          log_id [$];
  logic [7:0]  log_data [$];

  int          m_owner;
  int          m_count;
  int          m_ptr;

  logic [3:0]  acc_s;
  logic        wen_s;
  logic [7:0]  data_s;

  assign fifo_full = force_full | fifo_at_full;

  fifo_wr_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .accept       (accept),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester found walking start, start+1, ... modulo N_REQ.
  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(start + k) % N_REQ]) return (start + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_count = 0;
    m_ptr   = 0;
  endtask

  // One clock edge of the arbiter rules, evaluated on the inputs that were
  // present at that edge.
  task automatic model_step();
    logic acc_m;
    if (m_owner < 0) begin
      m_owner = pick(req, m_ptr);
      m_count = 0;
    end else begin
      acc_m = req[m_owner] && !fifo_full;
      if (acc_m) m_count++;
      if ((acc_m && m_count == MAX_BURST) || (!req[m_owner] && !fifo_full)) begin
        m_ptr   = (m_owner + 1) % N_REQ;
        m_owner = pick(req, m_ptr);
        m_count = 0;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N_REQ; i++) begin
      req[i] = (rem[i] != 0);
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = pdata[i];
    end
  endtask

  // Per-cycle comparison against the model, then capture of what the DUT
  // actually handed to the FIFO.
  task automatic compare_cycle();
    logic [3:0] exp_gnt;
    logic [1:0] exp_id;
    logic [3:0] exp_acc;
    logic [7:0] exp_data;
    exp_gnt  = 4'b0;
    exp_id   = 2'd0;
    exp_acc  = 4'b0;
    exp_data = 8'h00;
    if (m_owner >= 0) begin
      exp_gnt  = 4'b0001 << m_owner;
      exp_id   = 2'(m_owner);
      exp_data = req_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
      if (req[m_owner] && !fifo_full) exp_acc = exp_gnt;
    end
    checkOutput("gnt", gnt, exp_gnt);
    checkOutput("gnt_id", gnt_id, exp_id);
    checkOutput("busy", busy, (m_owner >= 0));
    checkOutput("accept", accept, exp_acc);
    checkOutput("fifo_w_en", fifo_w_en, |exp_acc);
    checkOutput("fifo_data_in", fifo_data_in, exp_data);
    acc_s  = accept;
    wen_s  = fifo_w_en;
    data_s = fifo_data_in;
    if (fifo_w_en) begin
      log_id.push_back(int'(gnt_id));
      log_data.push_back(fifo_data_in);
    end
  endtask

  task automatic env_update();
    if (wen_s) fq.push_back(data_s);
    for (int i = 0; i < N_REQ; i++) begin
      if (acc_s[i]) begin
        if (rem[i] > 0) rem[i]--;
        pdata[i] = pdata[i] + 8'd1;
      end
    end
    if (drain && fq.size() > 0) void'(fq.pop_front());
    fifo_at_full = (fq.size() >= FIFO_DEPTH);
    drive_inputs();
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    if (rst_n) model_step();
    env_update();
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int words, input logic full_in, input logic drain_in);
    for (int i = 0; i < N_REQ; i++) begin
      if (mask[i]) rem[i] = words;
    end
    force_full = full_in;
    drain      = drain_in;
    drive_inputs();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    fq.delete();
    log_id.delete();
    log_data.delete();
    fifo_at_full = 1'b0;
    force_full   = 1'b0;
    drain        = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      rem[i]   = 0;
      pdata[i] = base[i];
    end
    drive_inputs();
    #1;
    checkOutput("reset gnt", gnt, 4'b0000);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset fifo_w_en", fifo_w_en, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int cnt2;
    int idx;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    base[0] = 8'h11;
    base[1] = 8'h21;
    base[2] = 8'h31;
    base[3] = 8'h41;
    force_full   = 1'b0;
    fifo_at_full = 1'b0;
    drain        = 1'b0;
    acc_s  = 4'b0;
    wen_s  = 1'b0;
    data_s = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      rem[i]   = 0;
      pdata[i] = base[i];
    end
    drive_inputs();
    model_reset();
    #2;

    $display("[TB] single requester, FIFO not drained");
    reset_dut();
    applyStimulus(4'b0001, 1000, 1'b0, 1'b0);
    tick();
    checkOutput("t1 first grant", gnt, 4'b0001);
    checkOutput("t1 busy", busy, 1'b1);
    repeat (12) tick();
    checkOutput("t1 words written", log_id.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < log_data.size()) checkOutput("t1 data", log_data[k], 8'h11 + 8'(k));
    end
    checkOutput("t1 full w_en", fifo_w_en, 1'b0);
    checkOutput("t1 grant held", gnt, 4'b0001);

    $display("[TB] four requesters, FIFO drained");
    reset_dut();
    applyStimulus(4'b1111, 1000, 1'b0, 1'b1);
    tick();
    checkOutput("t2 first grant", gnt, 4'b0001);
    repeat (20) tick();
    checkOutput("t2 enough writes", (log_id.size() >= 17), 1'b1);
    for (int k = 0; k < 17; k++) begin
      if (k < log_id.size()) begin
        idx = (k / 4) % 4;
        checkOutput("t2 order id", log_id[k], idx);
        checkOutput("t2 order data", log_data[k], base[idx] + 8'((k / 16) * 4 + (k % 4)));
      end
    end

    $display("[TB] full stall on requester 2");
    reset_dut();
    applyStimulus(4'b1100, 1000, 1'b0, 1'b1);
    tick();
    checkOutput("t3 grant 2", gnt, 4'b0100);
    tick();
    tick();
    checkOutput("t3 two writes", log_id.size(), 2);
    applyStimulus(4'b0000, 0, 1'b1, 1'b1);
    #1;
    checkOutput("t3 stall w_en", fifo_w_en, 1'b0);
    checkOutput("t3 stall accept", accept, 4'b0000);
    checkOutput("t3 stall gnt", gnt, 4'b0100);
    repeat (5) begin
      tick();
      checkOutput("t3 held gnt", gnt, 4'b0100);
      checkOutput("t3 held w_en", fifo_w_en, 1'b0);
    end
    applyStimulus(4'b0000, 0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("t3 rotate to 3", gnt, 4'b1000);
    checkOutput("t3 total writes", log_id.size(), 4);
    cnt2 = 0;
    foreach (log_id[k]) if (log_id[k] == 2) cnt2++;
    checkOutput("t3 writes by 2", cnt2, 4);

    $display("[TB] early drop then async reset mid-burst");
    reset_dut();
    applyStimulus(4'b1000, 1000, 1'b0, 1'b1);
    applyStimulus(4'b0010, 2, 1'b0, 1'b1);
    tick();
    checkOutput("t4 grant 1", gnt, 4'b0010);
    tick();
    tick();
    applyStimulus(4'b0001, 1000, 1'b0, 1'b1);
    #1;
    checkOutput("t4 release cycle gnt", gnt, 4'b0010);
    checkOutput("t4 release cycle w_en", fifo_w_en, 1'b0);
    tick();
    checkOutput("t4 grant 3 after drop", gnt, 4'b1000);
    tick();
    #1;
    checkOutput("t5 second write live", fifo_w_en, 1'b1);
    checkOutput("t5 owner 3", gnt, 4'b1000);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("t5 async gnt", gnt, 4'b0000);
    checkOutput("t5 async w_en", fifo_w_en, 1'b0);
    checkOutput("t5 async busy", busy, 1'b0);
    checkOutput("t5 async accept", accept, 4'b0000);
    applyStimulus(4'b1111, 1000, 1'b0, 1'b1);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("t5 restart gnt", gnt, 4'b0001);
    checkOutput("t5 restart gnt_id", gnt_id, 2'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
